alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Ports SHALL be as follows. Clock and reset come first: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only when the block can accept.
- ALU  in  4  operation code from ALUcontrol.
- A  in  32  operand rs.
- B  in  32  operand rt.
- shamt  in  5  shift amount.
- busy  out  1  high while an accepted shift is in progress.
- done  out  1  one-cycle pulse: result/flags valid.
- result  out  32  registered result.
- zero  out  1  registered (result==0).
- overflow  out  1  registered signed overflow for ADD/SUB.
- illegal  out  1  registered unknown-code flag.

REQ-002 Parameters SHALL be as follows:
- CODE_AND, 4'b0000, AND.
- CODE_OR, 4'b0001, OR.
- CODE_ADD, 4'b0010, add.
- CODE_SUB, 4'b0110, subtract.
- CODE_SLT, 4'b0111, set-less-than.
- CODE_NOR, 4'b1100, NOR.
- CODE_SLL, 4'b1000, shift left logical.
- CODE_SRL, 4'b1001, shift right logical.

Function
REQ-003 The FSM SHALL have states IDLE, SHIFT and DONE; start SHALL be accepted only in IDLE or DONE, and ignored in SHIFT.
REQ-004 On acceptance of a non-shift code, or of a shift with shamt==0, the block SHALL load result and flags, go to DONE and pulse done in the next cycle (latency 1).
REQ-005 On acceptance of SLL/SRL with shamt=n>0, the block SHALL load result=B and cnt=n, and go to SHIFT.
REQ-006 In SHIFT, each cycle SHALL shift result by one bit (zero fill) and decrement cnt; the cycle with cnt==1 SHALL go to DONE, so done pulses n+1 cycles after acceptance.
REQ-007 busy SHALL be 1 exactly while in SHIFT.
REQ-008 done SHALL be 1 exactly while in DONE, for one cycle.
REQ-009 DONE SHALL go to IDLE, or accept a new start directly, giving back-to-back ops with no bubble.
REQ-010 ADD and SUB SHALL be 32-bit modulo; overflow SHALL be 1 when the operands' signs match (ADD) or differ (SUB) and the result sign differs from A.
REQ-011 overflow SHALL be 0 for every other code.
REQ-012 SLT SHALL give result={31'b0, signed(A)<signed(B)}, correct even when A-B overflows.
REQ-013 AND, OR and NOR SHALL be bitwise on A and B.
REQ-014 An unknown code SHALL give result=0 and illegal=1, with latency 1; illegal SHALL be 0 for every legal code.
REQ-015 zero SHALL be updated together with result, including after each shift step.
REQ-016 result and all flags SHALL hold their values until the next accepted operation changes them.
REQ-017 Operand inputs SHALL be sampled only at acceptance; changes during SHIFT SHALL have no effect.

Reset
REQ-018 On reset: state=IDLE, cnt=0, result=0, zero=1, overflow=0, illegal=0, busy=0, done=0.
REQ-019 Reset during SHIFT or DONE SHALL abort the operation with no done pulse; reset SHALL dominate a simultaneous start.

Structure
REQ-020 The CODE_* constants and the state encoding SHALL live in a shared package alu_codes_pkg, also used by ALUcontrol.
REQ-021 Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR, overflow, illegal) SHALL sit in a combinational sub-module alu_logic_unit.
REQ-022 The FSM, shift counter and output registers SHALL sit in alu_exec.

Verification
REQ-023 ADD with A=32'h7FFFFFFF, B=1 -> one cycle later done=1, result=32'h80000000, overflow=1, zero=0.
REQ-024 SUB with A=5, B=5 -> result=0, zero=1, overflow=0 at latency 1.
REQ-025 SLT with A=32'h80000000, B=1 -> result=1.
REQ-026 SLL with B=32'h00000003, shamt=4 -> busy for 4 cycles, done 5 cycles after accept, result=32'h00000030.
REQ-027 SRL with shamt=0 -> done at latency 1 with result=B.
REQ-028 Code 4'b0101 -> illegal=1, result=0, zero=1.
REQ-029 SRL with shamt=31, then reset at the 10th SHIFT cycle -> no done; all outputs equal their reset values.
REQ-030 A start during SHIFT is ignored.
REQ-031 A start in DONE is accepted; two back-to-back ADDs give done pulses one cycle apart with both results correct.

Source files
------------

// File: rtl/alu_codes_pkg.sv
// Shared ALU operation codes and execution-unit state encoding,
// used by both ALUcontrol and the execution datapath.
package alu_codes_pkg;

  localparam logic [3:0] CODE_AND = 4'b0000;
  localparam logic [3:0] CODE_OR  = 4'b0001;
  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;
  localparam logic [3:0] CODE_SLT = 4'b0111;
  localparam logic [3:0] CODE_NOR = 4'b1100;
  localparam logic [3:0] CODE_SLL = 4'b1000;
  localparam logic [3:0] CODE_SRL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_code(input logic [3:0] code);
    return (code == CODE_SLL) || (code == CODE_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational single-cycle ALU operations with overflow and illegal-code flags.
// Shift codes pass B through; the multi-cycle shifting lives in alu_exec.
module alu_logic_unit
  import alu_codes_pkg::*;
(
  input  logic [3:0]  alu,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        illegal
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (alu)
      CODE_AND: result = a & b;
      CODE_OR:  result = a | b;
      CODE_NOR: result = ~(a | b);
      CODE_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      CODE_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      // Signed compare directly rather than via diff so overflow cannot corrupt it
      CODE_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      CODE_SLL, CODE_SRL: result = b;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle ops via alu_logic_unit, plus a
// one-bit-per-cycle shifter for SLL/SRL with a done handshake.
module alu_exec
  import alu_codes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ALU,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        illegal
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  cnt;
  logic        shift_right;
  logic        accept;
  logic        multi_shift;
  logic [31:0] shifted;
  logic [31:0] lu_result;
  logic        lu_overflow;
  logic        lu_illegal;

  alu_logic_unit u_logic (
    .alu      (ALU),
    .a        (A),
    .b        (B),
    .result   (lu_result),
    .overflow (lu_overflow),
    .illegal  (lu_illegal)
  );

  assign accept      = start && (state != SHIFT);
  assign multi_shift = is_shift_code(ALU) && (shamt != 5'd0);
  assign shifted     = shift_right ? (result >> 1) : (result << 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = multi_shift ? SHIFT : DONE;
        else       next_state = IDLE;
      end
      SHIFT:   if (cnt == 5'd1) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Operands are captured only on acceptance; SHIFT works on the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      shift_right <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      overflow    <= 1'b0;
      illegal     <= 1'b0;
    end else if (accept) begin
      if (multi_shift) begin
        cnt         <= shamt;
        shift_right <= (ALU == CODE_SRL);
        result      <= B;
        zero        <= (B == 32'd0);
        overflow    <= 1'b0;
        illegal     <= 1'b0;
      end else begin
        cnt         <= '0;
        result      <= lu_result;
        zero        <= (lu_result == 32'd0);
        overflow    <= lu_overflow;
        illegal     <= lu_illegal;
      end
    end else if (state == SHIFT) begin
      cnt    <= cnt - 5'd1;
      result <= shifted;
      zero   <= (shifted == 32'd0);
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: a driver pushes model predictions on acceptance,
// a monitor compares them whenever done is expected or observed.
module tb_alu_exec;
  import alu_codes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALU;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        illegal;

  alu_exec dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALU      (ALU),
    .A        (A),
    .B        (B),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          accept_edge;
    int          done_edge;
    bit          is_shift;
    logic [31:0] res;
    bit          ov;
    bit          ill;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt = 0;
  int          free_edge = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] hold_res = '0;
  bit          hold_ov = 1'b0;
  bit          hold_ill = 1'b0;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Reference model: plain arithmetic on the operation's meaning
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] n);
    exp_t   e;
    longint sa;
    longint sbv;
    longint wide;
    sa    = longint'(int'(a));
    sbv   = longint'(int'(b));
    e.res = '0;
    e.ov  = 1'b0;
    e.ill = 1'b0;
    e.is_shift = 1'b0;
    e.accept_edge = 0;
    e.done_edge = 0;
    case (op)
      CODE_AND: e.res = a & b;
      CODE_OR:  e.res = a | b;
      CODE_NOR: e.res = ~(a | b);
      CODE_ADD: begin
        wide  = sa + sbv;
        e.res = wide[31:0];
        e.ov  = (wide != longint'(int'(wide[31:0])));
      end
      CODE_SUB: begin
        wide  = sa - sbv;
        e.res = wide[31:0];
        e.ov  = (wide != longint'(int'(wide[31:0])));
      end
      CODE_SLT: e.res = (sa < sbv) ? 32'd1 : 32'd0;
      CODE_SLL: begin e.res = b << n; e.is_shift = (n != 0); end
      CODE_SRL: begin e.res = b >> n; e.is_shift = (n != 0); end
      default:  e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] n);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    ALU   = op;
    A     = a;
    B     = b;
    shamt = n;
    if (edge_cnt + 1 >= free_edge) begin
      e = model(op, a, b, n);
      e.accept_edge = edge_cnt + 1;
      e.done_edge   = e.accept_edge + (e.is_shift ? int'(n) : 0);
      free_edge     = e.done_edge + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    start = 1'b0;
    ALU   = 4'($urandom);
    A     = $urandom;
    B     = $urandom;
    shamt = 5'($urandom);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    sb.delete();
    free_edge = 0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   exp_done;
    bit   exp_busy;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", {31'b0, zero}, 32'd1);
        checkOutput("reset_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("reset_illegal", {31'b0, illegal}, 32'd0);
        hold_res = '0;
        hold_ov  = 1'b0;
        hold_ill = 1'b0;
      end else begin
        exp_done = (sb.size() > 0) && (sb[0].done_edge == edge_cnt);
        exp_busy = (sb.size() > 0) && sb[0].is_shift &&
                   (edge_cnt >= sb[0].accept_edge) && (edge_cnt < sb[0].done_edge);
        checkOutput("done", {31'b0, done}, {31'b0, exp_done});
        checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
        if (exp_done) begin
          e = sb.pop_front();
          checkOutput("result", result, e.res);
          checkOutput("zero", {31'b0, zero}, {31'b0, (e.res == 32'd0)});
          checkOutput("overflow", {31'b0, overflow}, {31'b0, e.ov});
          checkOutput("illegal", {31'b0, illegal}, {31'b0, e.ill});
          hold_res = e.res;
          hold_ov  = e.ov;
          hold_ill = e.ill;
        end else if (!exp_busy) begin
          checkOutput("hold_result", result, hold_res);
          checkOutput("hold_overflow", {31'b0, overflow}, {31'b0, hold_ov});
          checkOutput("hold_illegal", {31'b0, illegal}, {31'b0, hold_ill});
        end
      end
    end
  end

  logic [3:0] ops [10] = '{CODE_AND, CODE_OR, CODE_ADD, CODE_SUB, CODE_SLT,
                           CODE_NOR, CODE_SLL, CODE_SRL, 4'b0101, 4'b1111};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'h80000001};

  function automatic logic [31:0] pickOperand();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin : driver
    int waited;
    reset = 1'b1;
    start = 1'b0;
    ALU   = '0;
    A     = '0;
    B     = '0;
    shamt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    applyStimulus(CODE_ADD, 32'h7FFFFFFF, 32'd1, 5'd0);
    idleCycle();
    applyStimulus(CODE_SUB, 32'd5, 32'd5, 5'd0);
    idleCycle();
    applyStimulus(CODE_SLT, 32'h80000000, 32'd1, 5'd0);
    idleCycle();
    applyStimulus(CODE_SLL, 32'hDEAD0000, 32'h00000003, 5'd4);
    applyStimulus(CODE_ADD, 32'd1, 32'd2, 5'd0);
    repeat (5) idleCycle();
    applyStimulus(CODE_SRL, 32'd0, 32'hA5A5F00F, 5'd0);
    idleCycle();
    applyStimulus(4'b0101, 32'h12345678, 32'h9ABCDEF0, 5'd0);
    idleCycle();
    applyStimulus(CODE_ADD, 32'd100, 32'd23, 5'd0);
    applyStimulus(CODE_ADD, 32'hFFFFFFFF, 32'd1, 5'd0);
    idleCycle();
    applyStimulus(CODE_SRL, 32'd0, 32'hFFFFFFFF, 5'd31);
    repeat (9) idleCycle();
    doReset(2);
    idleCycle();

    for (int i = 0; i < 250; i++) begin
      logic [4:0] n;
      n = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus(ops[$urandom_range(0, 9)], pickOperand(), pickOperand(), n);
      repeat ($urandom_range(0, 2)) idleCycle();
    end

    idleCycle();
    waited = 0;
    while (sb.size() > 0 && waited < 200) begin
      idleCycle();
      waited++;
    end
    tests++;
    if (sb.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    repeat (2) idleCycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
